// File: rtl/sample_dac_serializer.sv
// SPI serializer for a 16-bit DAC: samples are queued in a 4-entry FIFO and
// shipped as {CMD, sample, 4'b0000} frames, MSB first, SPI mode 0.
module sample_dac_serializer #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [3:0]  CMD     = 4'b0011
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_strobe_i,
  input  logic       enable_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       cs_n_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic [2:0] fill_level_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_r;
  logic [7:0]  div_cnt_r;
  logic [4:0]  half_cnt_r;
  logic [15:0] shift_r;
  logic        sclk_r;
  logic        mosi_r;
  logic        cs_n_r;
  logic        busy_r;
  logic        overflow_r;
  logic [7:0]  mem_r [4];
  logic [1:0]  wr_ptr_r;
  logic [1:0]  rd_ptr_r;
  logic [2:0]  count_r;
  logic        strb_r;
  logic [7:0]  data_r;
  logic        pop_s;
  logic        wr_s;
  logic        drop_s;
  logic        div_done_s;

  // FIFO handshake: a pop frees a slot in the same cycle, so a full FIFO still accepts then.
  always_comb begin
    pop_s      = 1'b0;
    wr_s       = 1'b0;
    drop_s     = 1'b0;
    div_done_s = (div_cnt_r == DIV_LAST);
    if ((state_r == IDLE) && enable_i && (count_r != 3'd0)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (strb_r && ((count_r != 3'd4) || pop_s)) begin
      wr_s = 1'b1;
    end else begin
      wr_s = 1'b0;
    end
    if (strb_r && !wr_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Input capture stage for the strobe and its sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      strb_r <= 1'b0;
      data_r <= 8'd0;
    end else begin
      strb_r <= data_valid_strobe_i;
      if (data_valid_strobe_i) begin
        data_r <= data_i;
      end
    end
  end

  // Sample storage; validity is tracked by count_r, so the array needs no reset.
  always_ff @(posedge clk_i) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= data_r;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      count_r    <= 3'd0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({wr_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Frame sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      div_cnt_r  <= 8'd0;
      half_cnt_r <= 5'd0;
      shift_r    <= 16'd0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sclk_r    <= 1'b0;
          div_cnt_r <= 8'd0;
          if (pop_s) begin
            state_r    <= LOAD;
            shift_r    <= {CMD, mem_r[rd_ptr_r], 4'b0000};
            mosi_r     <= CMD[3];
            cs_n_r     <= 1'b0;
            busy_r     <= 1'b1;
            half_cnt_r <= 5'd0;
          end else begin
            mosi_r <= 1'b0;
            cs_n_r <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        LOAD: begin
          state_r   <= SHIFT;
          div_cnt_r <= 8'd0;
        end
        SHIFT: begin
          if (div_done_s) begin
            div_cnt_r  <= 8'd0;
            sclk_r     <= ~sclk_r;
            half_cnt_r <= half_cnt_r + 5'd1;
            // Data advances on the falling edge so it is stable at the next rise.
            if (sclk_r) begin
              mosi_r  <= shift_r[14];
              shift_r <= {shift_r[14:0], 1'b0};
            end
            if (half_cnt_r == 5'd31) begin
              state_r <= HOLD;
            end
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        HOLD: begin
          if (div_done_s) begin
            state_r   <= GAP;
            div_cnt_r <= 8'd0;
            cs_n_r    <= 1'b1;
            mosi_r    <= 1'b0;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        GAP: begin
          if (div_done_s) begin
            state_r   <= IDLE;
            div_cnt_r <= 8'd0;
            busy_r    <= 1'b0;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          div_cnt_r <= 8'd0;
          sclk_r    <= 1'b0;
          mosi_r    <= 1'b0;
          cs_n_r    <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign sclk_o       = sclk_r;
  assign mosi_o       = mosi_r;
  assign cs_n_o       = cs_n_r;
  assign busy_o       = busy_r;
  assign overflow_o   = overflow_r;
  assign fill_level_o = count_r;

endmodule

// File: tb/tb_sample_dac_serializer.sv
// Scoreboard bench: stimulus queues expected 16-bit frames, an SPI monitor
// reassembles frames from the pins and checks word, framing and gap timing.
module tb_sample_dac_serializer;

  localparam int         D   = 2;
  localparam logic [3:0] CMD = 4'b0011;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] data_i = 8'd0;
  logic       data_valid_strobe_i = 1'b0;
  logic       enable_i = 1'b0;
  logic       sclk_o, mosi_o, cs_n_o, busy_o, overflow_o;
  logic [2:0] fill_level_o;

  sample_dac_serializer #(.CLK_DIV(D), .CMD(CMD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i),
    .data_valid_strobe_i(data_valid_strobe_i), .enable_i(enable_i),
    .sclk_o(sclk_o), .mosi_o(mosi_o), .cs_n_o(cs_n_o), .busy_o(busy_o),
    .overflow_o(overflow_o), .fill_level_o(fill_level_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  int frames_done = 0;
  int cur_rises = 0;
  int last_gap = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] frame_of(input logic [7:0] d);
    return {CMD, d, 4'b0000};
  endfunction

  // SPI monitor: samples pins on the falling clk edge, away from DUT updates.
  int          low_cnt = 0;
  int          high_cnt = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [15:0] word = 16'd0;
  bit          have_prev = 1'b0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      have_prev = 1'b0;
      cur_rises = 0;
      low_cnt   = 0;
      high_cnt  = 0;
    end else begin
      if (!cs_n_o) begin
        if (prev_cs) begin
          if (have_prev) begin
            last_gap = high_cnt;
            check("cs_gap_min", (high_cnt >= D + 1), 1);
          end
          low_cnt   = 0;
          cur_rises = 0;
          word      = 16'd0;
        end
        low_cnt++;
        if (sclk_o && !prev_sclk) begin
          word = {word[14:0], mosi_o};
          cur_rises++;
        end
      end else begin
        if (!prev_cs) begin
          frames_done++;
          check("cs_low_cycles", low_cnt, 1 + 33 * D);
          check("sclk_rises", cur_rises, 16);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", word, 32'hFFFF_FFFF);
          end else begin
            check("frame_word", word, exp_q.pop_front());
          end
          have_prev = 1'b1;
          high_cnt  = 0;
        end
        high_cnt++;
        check("idle_mosi_sclk", {mosi_o, sclk_o}, 0);
      end
      prev_cs   = cs_n_o;
      prev_sclk = sclk_o;
    end
  end

  // Call at a negedge; holds the strobe for exactly one clock.
  task automatic put(input logic [7:0] d, input bit expect_frame);
    data_i = d;
    data_valid_strobe_i = 1'b1;
    if (expect_frame) exp_q.push_back(frame_of(d));
    @(negedge clk_i);
    data_valid_strobe_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_i);
      if (!busy_o && cs_n_o && fill_level_o == 3'd0 && exp_q.size() == 0) begin
        idle = 1'b1;
        break;
      end
    end
    check(name, idle, 1);
  endtask

  task automatic wait_rises(input int n, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i);
      if (!cs_n_o && cur_rises >= n) begin
        hit = 1'b1;
        break;
      end
    end
    check(name, hit, 1);
  endtask

  initial begin
    int f0;
    int n;
    logic [7:0] d;
    bit gone;

    // Reset state
    #1 rst_i = 1'b1;
    #1;
    check("rst_outputs", {cs_n_o, sclk_o, mosi_o, busy_o, overflow_o, fill_level_o}, 8'b1000_0000);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("post_rst_idle", {cs_n_o, busy_o, fill_level_o}, 5'b1_0_000);

    // Single frame with start latency
    enable_i = 1'b1;
    @(negedge clk_i);
    data_i = 8'hA5;
    data_valid_strobe_i = 1'b1;
    exp_q.push_back(frame_of(8'hA5));
    @(posedge clk_i);
    @(negedge clk_i);
    data_valid_strobe_i = 1'b0;
    @(posedge clk_i);
    #1 check("cs_latency_n1", cs_n_o, 1);
    @(posedge clk_i);
    #1 check("cs_latency_n2", cs_n_o, 0);
    check("busy_in_frame", busy_o, 1);
    wait_idle("single_frame_done");

    // Back-to-back frames
    put(8'h01, 1'b1);
    put(8'h02, 1'b1);
    put(8'h03, 1'b1);
    wait_idle("b2b_done");
    check("b2b_gap", last_gap, D + 1);

    // Overflow with frames held off
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) put(8'(8'h10 + i), (i < 4));
    repeat (3) @(negedge clk_i);
    check("ovf_fill", fill_level_o, 4);
    check("ovf_flag", overflow_o, 1);
    check("ovf_no_frame", busy_o, 0);
    enable_i = 1'b1;
    wait_idle("ovf_drain");
    check("ovf_sticky", overflow_o, 1);

    // Reset mid-frame
    put(8'h81, 1'b1);
    put(8'h82, 1'b1);
    wait_rises(8, "rst_reach_rise8");
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_cs_sclk", {cs_n_o, sclk_o}, 2'b10);
    check("rst_fill_ovf", {fill_level_o, overflow_o, busy_o, mosi_o}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    f0 = frames_done;
    repeat (150) @(negedge clk_i);
    check("rst_no_frames", frames_done, f0);
    check("rst_still_empty", fill_level_o, 0);

    // Write coincident with a pop from a full FIFO
    enable_i = 1'b0;
    for (int i = 0; i < 4; i++) put(8'(8'h20 + i), 1'b1);
    repeat (2) @(negedge clk_i);
    check("wdp_full", fill_level_o, 4);
    data_i = 8'h24;
    data_valid_strobe_i = 1'b1;
    exp_q.push_back(frame_of(8'h24));
    @(negedge clk_i);
    data_valid_strobe_i = 1'b0;
    enable_i = 1'b1;
    wait_idle("wdp_drain");
    check("wdp_no_overflow", overflow_o, 0);

    // Mid-frame disable
    f0 = frames_done;
    put(8'h5A, 1'b1);
    put(8'hC3, 1'b1);
    wait_rises(5, "dis_reach_rise5");
    enable_i = 1'b0;
    gone = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i);
      if (!busy_o) begin
        gone = 1'b1;
        break;
      end
    end
    check("dis_busy_clears", gone, 1);
    check("dis_one_frame", frames_done, f0 + 1);
    check("dis_fill", fill_level_o, 1);
    put(8'h77, 1'b1);
    repeat (150) @(negedge clk_i);
    check("dis_still_one", frames_done, f0 + 1);
    check("dis_write_active", fill_level_o, 2);
    check("dis_idle", busy_o, 0);
    enable_i = 1'b1;
    wait_idle("dis_resume");

    // Randomized bursts of up to four samples
    for (int b = 0; b < 6; b++) begin
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom_range(0, 255));
        put(d, 1'b1);
        repeat ($urandom_range(0, 1)) @(negedge clk_i);
      end
      wait_idle("rand_burst");
    end
    check("final_overflow", overflow_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_dac_serializer.md
SAMPLE_DAC_SERIALIZER -- requirements
Module: sample_dac_serializer

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2, meaning the SCLK half-period in clk_i cycles; legal range is 1..255.
REQ-002 SHALL provide parameter CMD, default 4'b0011, meaning the DAC command nibble sent in each frame.
REQ-003 SHALL provide port clk_i, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL provide port rst_i, input, width 1: asynchronous, active-high reset.
REQ-005 SHALL provide port data_i, input, width 8: unsigned sample from the waveform generator output.
REQ-006 SHALL provide port data_valid_strobe_i, input, width 1: one-cycle strobe qualifying data_i.
REQ-007 SHALL provide port enable_i, input, width 1: permits new frames to start.
REQ-008 SHALL provide port sclk_o, output, width 1: SPI clock, mode 0, idle low.
REQ-009 SHALL provide port mosi_o, output, width 1: SPI data, MSB first.
REQ-010 SHALL provide port cs_n_o, output, width 1: active-low DAC chip select.
REQ-011 SHALL provide port busy_o, output, width 1: high whenever the FSM is not in IDLE.
REQ-012 SHALL provide port overflow_o, output, width 1: sticky flag indicating a dropped sample.
REQ-013 SHALL provide port fill_level_o, output, width 3: current FIFO occupancy, 0..4.

Function
REQ-014 SHALL buffer samples in a 4-entry FIFO: write on data_valid_strobe_i when not full; FIFO order is preserved.
REQ-015 SHALL handle a strobe while full as follows: drop the sample, leave FIFO contents unchanged, set overflow_o until reset.
REQ-016 SHALL accept the write when a strobe coincides with a pop (LOAD) while full; fill_level_o stays 4 and overflow_o is not set.
REQ-017 SHALL handle a strobe while empty by writing the sample; fill_level_o becomes 1 on the next edge.
REQ-018 SHALL implement FSM states IDLE, LOAD, SHIFT, HOLD, GAP; all outputs SHALL be registered.
REQ-019 SHALL, in IDLE, hold cs_n_o=1 and sclk_o=0, and go to LOAD when enable_i=1 and the FIFO is not empty.
REQ-020 SHALL, in LOAD (1 cycle), pop the head entry, load shift register {CMD, sample, 4'b0000} (16 bits), and drive cs_n_o=0, sclk_o=0, mosi_o=bit 15.
REQ-021 SHALL, in SHIFT, toggle sclk_o every CLK_DIV cycles for 32 half-periods (16 rising edges) and advance mosi_o on each falling edge; SHIFT ends with sclk_o low.
REQ-022 SHALL, in HOLD, keep cs_n_o=0 and sclk_o=0 for CLK_DIV cycles, then enter GAP.
REQ-023 SHALL, in GAP, drive cs_n_o=1 for CLK_DIV cycles, then enter IDLE.
REQ-024 SHALL keep cs_n_o low for exactly 1 + 33*CLK_DIV cycles per frame (67 cycles at CLK_DIV=2).
REQ-025 SHALL keep cs_n_o high between back-to-back frames for CLK_DIV+1 cycles minimum.
REQ-026 SHALL, for a strobe sampled at edge N with the FIFO empty, the FSM in IDLE and enable_i=1, drive cs_n_o low after edge N+2.
REQ-027 SHALL, on enable_i deassertion mid-frame, complete the current frame, start no new frame, and keep FIFO writes active.
REQ-028 SHALL hold mosi_o at 0 outside LOAD/SHIFT/HOLD.
REQ-029 SHALL keep fill_level_o equal to writes minus pops and never exceeding 4.

Reset
REQ-030 SHALL, on rst_i=1, immediately and asynchronously set: FSM to IDLE, FIFO empty, fill_level_o=0, overflow_o=0, cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0.
REQ-031 SHALL, on reset asserted mid-frame, abort the frame; cs_n_o rises without waiting for a clk_i edge.
REQ-032 SHALL sample no inputs on the first clk_i edge after rst_i deasserts other than data_valid_strobe_i and enable_i.

Verification
REQ-033 SHALL cover a single frame: CLK_DIV=2, enable_i=1, strobe data_i=8'hA5 -> MOSI bits 0011_1010_0101_0000, 16 SCLK rises, cs_n_o low 67 cycles.
REQ-034 SHALL cover back-to-back frames: 3 strobes 8'h01, 8'h02, 8'h03 within 3 cycles -> 3 frames in order, cs_n_o high 3 cycles between frames.
REQ-035 SHALL cover overflow: enable_i=0, 5 strobes 8'h10..8'h14 -> fill_level_o=4, overflow_o=1; then enable_i=1 -> frames 10,11,12,13 only.
REQ-036 SHALL cover write during pop: FIFO full, strobe coincident with LOAD -> sample accepted, overflow_o stays 0.
REQ-037 SHALL cover the mid-frame disable: enable_i dropped at SCLK rise 5 -> frame completes, no further frames, busy_o=0 after GAP.
REQ-038 SHALL cover reset mid-frame: rst_i pulsed at SCLK rise 8 -> cs_n_o=1, sclk_o=0 asynchronously, fill_level_o=0, overflow_o=0.
